// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
//
// Read-side sequencer for the dual-buffered LED framebuffer. For every row
// pair and every BCM bit plane it reads one line of pixels from the front
// buffer, shifts them into the HUB75 panel chain, latches the line and then
// lights it for a binary-weighted time (BASE_CYCLES << plane). It also owns
// the front/back buffer swap, which only ever happens on a frame boundary.
//
// Ports
//   clk, rst            read-domain clock, synchronous active-high reset
//   ctrl_en             scan enable (honoured when idle and at frame ends)
//   ctrl_n_rows/cols    panel geometry, sampled when a frame starts
//   ctrl_bitdepth       planes per colour, sampled when a frame starts
//   swap_req/swap_ack   writer swap handshake (ack is a 1-cycle pulse)
//   frame_done          1-cycle pulse in the final display cycle of a frame
//   fb_r_*              framebuffer read port, fb_r_dout valid 1 cycle later
//   hub75_*             panel data, shift clock, latch, OE (active low), row
//
// Build option
//   SCAN_BRIGHTNESS_EN  adds ctrl_brightness[7:0]; OE is then only asserted
//                       in DISPLAY while a free-running 8-bit counter is
//                       below ctrl_brightness. Without it OE is asserted for
//                       the whole DISPLAY period.
//
// All outputs are registered. Output register values are computed from the
// next-cycle sequencer position so that they line up with the state they
// describe.

module hub75_scan_ctrl #(
    parameter int N_ROWS_MAX       = 64,
    parameter int N_COLS_MAX       = 256,
    parameter int BITDEPTH_MAX     = 8,
    parameter int CTRL_REG_WIDTH   = 32,
    parameter int BASE_CYCLES      = 16,
    parameter int MEM_R_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0]         ctrl_bitdepth,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [7:0]                        ctrl_brightness,
`endif
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              frame_done,
    output logic                              fb_r_en,
    output logic                              fb_r_buffer,
    output logic [MEM_R_ADDR_WIDTH-1:0]       fb_r_addr,
    output logic [$clog2(BITDEPTH_MAX)-1:0]   fb_r_bit,
    input  logic [5:0]                        fb_r_dout,
    output logic [5:0]                        hub75_rgb,
    output logic                              hub75_clk,
    output logic                              hub75_lat,
    output logic                              hub75_oe_n,
    output logic [$clog2(N_ROWS_MAX)-2:0]     hub75_row
);

    localparam int ROW_W   = $clog2(N_ROWS_MAX) - 1;
    localparam int PLANE_W = $clog2(BITDEPTH_MAX);
    localparam int COL_W   = $clog2(N_COLS_MAX + 1);
    localparam int T_W     = $clog2(2 * N_COLS_MAX + 2);
    localparam int DISP_W  = $clog2(BASE_CYCLES << (BITDEPTH_MAX - 1)) + 1;
    localparam int ADDR_W  = MEM_R_ADDR_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_LATCH   = 2'd2;
    localparam logic [1:0] S_DISPLAY = 2'd3;

    // Last display-counter value of a plane: BASE_CYCLES << p, minus one.
    function automatic logic [DISP_W-1:0] disp_last(input logic [PLANE_W-1:0] p);
        return (DISP_W'(BASE_CYCLES) << p) - DISP_W'(1);
    endfunction

    // Sequencer position
    logic [1:0]         state_q, state_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic [ADDR_W-1:0]  base_q, base_d;

    // Frame configuration, captured only when a frame starts
    logic [COL_W-1:0]   n_cols_q, n_cols_d;
    logic [ROW_W-1:0]   last_row_q, last_row_d;
    logic [PLANE_W-1:0] last_plane_q, last_plane_d;
    logic [T_W-1:0]     t_last_q, t_last_d;

    logic               pending_q, pending_d;

    // Output registers
    logic               swap_ack_q, swap_ack_d;
    logic               frame_done_q, frame_done_d;
    logic               fb_r_en_q, fb_r_en_d;
    logic               fb_r_buffer_q, fb_r_buffer_d;
    logic [ADDR_W-1:0]  fb_r_addr_q, fb_r_addr_d;
    logic [PLANE_W-1:0] fb_r_bit_q, fb_r_bit_d;
    logic [5:0]         hub75_rgb_q, hub75_rgb_d;
    logic               hub75_clk_q, hub75_clk_d;
    logic               hub75_lat_q, hub75_lat_d;
    logic               hub75_oe_n_q, hub75_oe_n_d;
    logic [ROW_W-1:0]   hub75_row_q, hub75_row_d;

`ifdef SCAN_BRIGHTNESS_EN
    logic [7:0]         bright_cnt_q, bright_cnt_d;
`endif

    logic               cfg_valid;
    logic               start_frame;
    logic               disp_on_d;

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        row_d        = row_q;
        plane_d      = plane_q;
        disp_d       = disp_q;
        base_d       = base_q;
        n_cols_d     = n_cols_q;
        last_row_d   = last_row_q;
        last_plane_d = last_plane_q;
        t_last_d     = t_last_q;
        start_frame  = 1'b0;

        cfg_valid = (ctrl_n_rows >= 2) && (ctrl_n_rows <= N_ROWS_MAX) &&
                    (ctrl_n_cols != 0) && (ctrl_n_cols <= N_COLS_MAX) &&
                    (ctrl_bitdepth != 0) && (ctrl_bitdepth <= BITDEPTH_MAX);

        case (state_q)
            S_IDLE: begin
                if (ctrl_en && cfg_valid) begin
                    start_frame = 1'b1;
                end
            end
            S_SHIFT: begin
                if (t_q == t_last_q) begin
                    state_d = S_LATCH;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                disp_d  = '0;
            end
            S_DISPLAY: begin
                if (disp_q == disp_last(plane_q)) begin
                    if (plane_q != last_plane_q) begin
                        state_d = S_SHIFT;
                        t_d     = '0;
                        plane_d = plane_q + PLANE_W'(1);
                    end else if (row_q != last_row_q) begin
                        // Next row pair: advance the row base by one line
                        // instead of multiplying row * n_cols.
                        state_d = S_SHIFT;
                        t_d     = '0;
                        plane_d = '0;
                        row_d   = row_q + ROW_W'(1);
                        base_d  = base_q + ADDR_W'(n_cols_q);
                    end else if (ctrl_en && cfg_valid) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    disp_d = disp_q + DISP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d      = S_SHIFT;
            t_d          = '0;
            row_d        = '0;
            plane_d      = '0;
            base_d       = '0;
            n_cols_d     = COL_W'(ctrl_n_cols);
            last_row_d   = ROW_W'((ctrl_n_rows >> 1) - 1);
            last_plane_d = PLANE_W'(ctrl_bitdepth - 1);
            t_last_d     = T_W'((ctrl_n_cols << 1) + 1);
        end

        // Pixel k is read at even t = 2k while t < 2*n_cols; its data is
        // registered onto the panel bus at t = 2k+2 and clocked at t = 2k+3.
        fb_r_en_d   = (state_d == S_SHIFT) && !t_d[0] && (t_d < t_last_d - T_W'(1));
        fb_r_addr_d = fb_r_addr_q;
        fb_r_bit_d  = fb_r_bit_q;
        if (fb_r_en_d) begin
            fb_r_addr_d = base_d + ADDR_W'(t_d >> 1);
            fb_r_bit_d  = plane_d;
        end

        hub75_rgb_d = hub75_rgb_q;
        if ((state_d == S_SHIFT) && !t_d[0] && (t_d >= T_W'(2))) begin
            hub75_rgb_d = fb_r_dout;
        end
        hub75_clk_d = (state_d == S_SHIFT) && t_d[0] && (t_d >= T_W'(3));

        hub75_lat_d = (state_d == S_LATCH);
        hub75_row_d = hub75_lat_d ? row_d : hub75_row_q;

`ifdef SCAN_BRIGHTNESS_EN
        bright_cnt_d = bright_cnt_q + 8'd1;
        disp_on_d    = (state_d == S_DISPLAY) && (bright_cnt_d < ctrl_brightness);
`else
        disp_on_d    = (state_d == S_DISPLAY);
`endif
        hub75_oe_n_d = !disp_on_d;

        // The frame boundary is the final display cycle of the last plane of
        // the last row pair. A request arriving on the edge into that cycle
        // is served immediately; any other request waits in pending.
        frame_done_d  = (state_d == S_DISPLAY) && (disp_d == disp_last(plane_d)) &&
                        (plane_d == last_plane_d) && (row_d == last_row_d);
        swap_ack_d    = frame_done_d && (pending_q || swap_req);
        pending_d     = swap_ack_d ? 1'b0 : (pending_q || swap_req);
        fb_r_buffer_d = fb_r_buffer_q ^ swap_ack_d;
    end

    // All sequencer, configuration and output registers; reset returns the
    // block to IDLE with the panel dark and any pending swap discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            t_q           <= '0;
            row_q         <= '0;
            plane_q       <= '0;
            disp_q        <= '0;
            base_q        <= '0;
            n_cols_q      <= '0;
            last_row_q    <= '0;
            last_plane_q  <= '0;
            t_last_q      <= '0;
            pending_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            fb_r_en_q     <= 1'b0;
            fb_r_buffer_q <= 1'b0;
            fb_r_addr_q   <= '0;
            fb_r_bit_q    <= '0;
            hub75_rgb_q   <= '0;
            hub75_clk_q   <= 1'b0;
            hub75_lat_q   <= 1'b0;
            hub75_oe_n_q  <= 1'b1;
            hub75_row_q   <= '0;
`ifdef SCAN_BRIGHTNESS_EN
            bright_cnt_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            disp_q        <= disp_d;
            base_q        <= base_d;
            n_cols_q      <= n_cols_d;
            last_row_q    <= last_row_d;
            last_plane_q  <= last_plane_d;
            t_last_q      <= t_last_d;
            pending_q     <= pending_d;
            swap_ack_q    <= swap_ack_d;
            frame_done_q  <= frame_done_d;
            fb_r_en_q     <= fb_r_en_d;
            fb_r_buffer_q <= fb_r_buffer_d;
            fb_r_addr_q   <= fb_r_addr_d;
            fb_r_bit_q    <= fb_r_bit_d;
            hub75_rgb_q   <= hub75_rgb_d;
            hub75_clk_q   <= hub75_clk_d;
            hub75_lat_q   <= hub75_lat_d;
            hub75_oe_n_q  <= hub75_oe_n_d;
            hub75_row_q   <= hub75_row_d;
`ifdef SCAN_BRIGHTNESS_EN
            bright_cnt_q  <= bright_cnt_d;
`endif
        end
    end

    assign swap_ack    = swap_ack_q;
    assign frame_done  = frame_done_q;
    assign fb_r_en     = fb_r_en_q;
    assign fb_r_buffer = fb_r_buffer_q;
    assign fb_r_addr   = fb_r_addr_q;
    assign fb_r_bit    = fb_r_bit_q;
    assign hub75_rgb   = hub75_rgb_q;
    assign hub75_clk   = hub75_clk_q;
    assign hub75_lat   = hub75_lat_q;
    assign hub75_oe_n  = hub75_oe_n_q;
    assign hub75_row   = hub75_row_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl
//
// Bench for hub75_scan_ctrl. A frame-level model expands each started frame
// into the list of cycles it must produce (nested row / plane / shift /
// latch / display loops), and every cycle the DUT outputs are compared with
// the head of that list. The bench also plays the framebuffer: read data is
// a fixed function of buffer, address and plane, returned one cycle after
// the read. Directed frames pin the model with hand-computed numbers, then
// a randomized run varies geometry, enable, swap requests and resets.

module tb_hub75_scan_ctrl;

    localparam int BASE = 4;

    logic        clk;
    logic        rst;
    logic        ctrl_en;
    logic [31:0] ctrl_n_rows;
    logic [31:0] ctrl_n_cols;
    logic [31:0] ctrl_bitdepth;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_done;
    logic        fb_r_en;
    logic        fb_r_buffer;
    logic [12:0] fb_r_addr;
    logic [2:0]  fb_r_bit;
    logic [5:0]  fb_r_dout;
    logic [5:0]  hub75_rgb;
    logic        hub75_clk;
    logic        hub75_lat;
    logic        hub75_oe_n;
    logic [4:0]  hub75_row;
`ifdef SCAN_BRIGHTNESS_EN
    logic [7:0]  bright;
`endif

    hub75_scan_ctrl #(.BASE_CYCLES(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_en       (ctrl_en),
        .ctrl_n_rows   (ctrl_n_rows),
        .ctrl_n_cols   (ctrl_n_cols),
        .ctrl_bitdepth (ctrl_bitdepth),
`ifdef SCAN_BRIGHTNESS_EN
        .ctrl_brightness(bright),
`endif
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .frame_done    (frame_done),
        .fb_r_en       (fb_r_en),
        .fb_r_buffer   (fb_r_buffer),
        .fb_r_addr     (fb_r_addr),
        .fb_r_bit      (fb_r_bit),
        .fb_r_dout     (fb_r_dout),
        .hub75_rgb     (hub75_rgb),
        .hub75_clk     (hub75_clk),
        .hub75_lat     (hub75_lat),
        .hub75_oe_n    (hub75_oe_n),
        .hub75_row     (hub75_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle of a frame
    typedef struct {
        bit en;
        int addr;
        int pbit;
        bit sclk;
        bit lat;
        int row;
        bit disp;
        bit fd;
        bit rgb_upd;
        int rgb_addr;
        int rgb_bit;
    } rec_t;

    rec_t exp_q[$];
    rec_t cur;

    int vectors = 0;
    int errors  = 0;

    // Model state
    int m_buf, m_pend, m_rgb, m_row, m_cnt, m_ack;

    // Framebuffer emulation state
    bit prev_en;
    int prev_addr, prev_bit, prev_buf;

    // Observations used by the directed literal checks
    int cyc, first_read, fd_cyc, ack_cyc, clk_cnt, oe_low, ack_cnt;
    int rgb_t8, clk_t8, clk_t9;
    int reads[$];
    int read_bits[$];

    function automatic int mem_val(input int buf_sel, input int addr, input int b);
        return (addr * 7 + b * 13 + buf_sel * 29 + 21) & 63;
    endfunction

    function automatic bit cfg_ok(input int r, input int c, input int d);
        return (r >= 2) && (r <= 64) && (c >= 1) && (c <= 256) && (d >= 1) && (d <= 8);
    endfunction

    // Expand one whole frame into its expected cycles
    task automatic gen_frame(input int rows, input int cols, input int bd);
        rec_t rc;
        for (int r = 0; r < rows / 2; r++) begin
            for (int b = 0; b < bd; b++) begin
                for (int t = 0; t < 2 * cols + 2; t++) begin
                    rc = '{default: 0};
                    rc.en       = (t % 2 == 0) && (t < 2 * cols);
                    rc.addr     = r * cols + t / 2;
                    rc.pbit     = b;
                    rc.sclk     = (t % 2 == 1) && (t >= 3);
                    rc.rgb_upd  = (t % 2 == 0) && (t >= 2);
                    rc.rgb_addr = r * cols + t / 2 - 1;
                    rc.rgb_bit  = b;
                    exp_q.push_back(rc);
                end
                rc = '{default: 0};
                rc.lat = 1'b1;
                rc.row = r;
                exp_q.push_back(rc);
                for (int d = 0; d < (BASE << b); d++) begin
                    rc = '{default: 0};
                    rc.disp = 1'b1;
                    rc.fd   = (r == rows / 2 - 1) && (b == bd - 1) && (d == (BASE << b) - 1);
                    exp_q.push_back(rc);
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic clear_obs();
        cyc = 0; first_read = -1; fd_cyc = -1; ack_cyc = -1;
        clk_cnt = 0; oe_low = 0; ack_cnt = 0;
        rgb_t8 = -1; clk_t8 = -1; clk_t9 = -1;
        reads.delete();
        read_bits.delete();
    endtask

    // One clock: advance the model with the inputs seen at the edge, compare
    // every output, then present read data for the previous cycle's read.
    task automatic applyStimulus();
        bit s_rst, s_en, s_swap;
        int s_rows, s_cols, s_bd, exp_oe;
        s_rst  = rst;
        s_en   = ctrl_en;
        s_swap = swap_req;
        s_rows = int'(ctrl_n_rows);
        s_cols = int'(ctrl_n_cols);
        s_bd   = int'(ctrl_bitdepth);
        @(posedge clk);
        #1;
        cyc++;

        if (s_rst) begin
            exp_q.delete();
            m_buf = 0; m_pend = 0; m_rgb = 0; m_row = 0; m_cnt = 0; m_ack = 0;
            cur = '{default: 0};
        end else begin
            m_cnt = (m_cnt + 1) % 256;
            if (exp_q.size() == 0 && s_en && cfg_ok(s_rows, s_cols, s_bd))
                gen_frame(s_rows, s_cols, s_bd);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{default: 0};
            m_ack = 0;
            if (cur.fd) begin
                if (m_pend != 0 || s_swap) begin
                    m_ack = 1; m_buf ^= 1; m_pend = 0;
                end
            end else if (s_swap) begin
                m_pend = 1;
            end
            if (cur.rgb_upd) m_rgb = mem_val(m_buf, cur.rgb_addr, cur.rgb_bit);
            if (cur.lat) m_row = cur.row;
        end

`ifdef SCAN_BRIGHTNESS_EN
        exp_oe = (cur.disp && (m_cnt < int'(bright))) ? 0 : 1;
`else
        exp_oe = cur.disp ? 0 : 1;
`endif

        checkOutput("fb_r_en", fb_r_en, cur.en);
        if (cur.en) begin
            checkOutput("fb_r_addr", fb_r_addr, cur.addr);
            checkOutput("fb_r_bit", fb_r_bit, cur.pbit);
        end
        checkOutput("hub75_clk", hub75_clk, cur.sclk);
        checkOutput("hub75_lat", hub75_lat, cur.lat);
        checkOutput("hub75_row", hub75_row, m_row);
        checkOutput("hub75_oe_n", hub75_oe_n, exp_oe);
        checkOutput("hub75_rgb", hub75_rgb, m_rgb);
        checkOutput("frame_done", frame_done, cur.fd);
        checkOutput("swap_ack", swap_ack, m_ack);
        checkOutput("fb_r_buffer", fb_r_buffer, m_buf);

        if (fb_r_en) begin
            reads.push_back(int'(fb_r_addr));
            read_bits.push_back(int'(fb_r_bit));
            if (first_read < 0) first_read = cyc;
        end
        if (first_read >= 0 && cyc == first_read + 8) begin
            rgb_t8 = hub75_rgb;
            clk_t8 = hub75_clk;
        end
        if (first_read >= 0 && cyc == first_read + 9) clk_t9 = hub75_clk;
        if (hub75_clk) clk_cnt++;
        if (!hub75_oe_n) oe_low++;
        if (frame_done && fd_cyc < 0) fd_cyc = cyc;
        if (swap_ack) begin
            ack_cnt++;
            if (ack_cyc < 0) ack_cyc = cyc;
        end

        fb_r_dout = prev_en ? 6'(mem_val(prev_buf, prev_addr, prev_bit)) : 6'($urandom);
        prev_en   = fb_r_en;
        prev_addr = int'(fb_r_addr);
        prev_bit  = int'(fb_r_bit);
        prev_buf  = int'(fb_r_buffer);
    endtask

    int exp_addr[16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
    int exp_bits[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        rst = 1'b1; ctrl_en = 1'b0; swap_req = 1'b0;
        ctrl_n_rows = 32'd4; ctrl_n_cols = 32'd4; ctrl_bitdepth = 32'd2;
        fb_r_dout = 6'd0;
        prev_en = 1'b0; prev_addr = 0; prev_bit = 0; prev_buf = 0;
        cur = '{default: 0};
`ifdef SCAN_BRIGHTNESS_EN
        bright = 8'd64;
`endif
        clear_obs();

        // Reset state
        repeat (3) applyStimulus();
        checkOutput("rst_oe_n", hub75_oe_n, 1);
        checkOutput("rst_fb_r_en", fb_r_en, 0);
        checkOutput("rst_buffer", fb_r_buffer, 0);
        checkOutput("rst_addr", fb_r_addr, 0);
        checkOutput("rst_rgb", hub75_rgb, 0);

        // Released but disabled: never reads
        rst = 1'b0;
        repeat (20) applyStimulus();
        checkOutput("idle_reads", reads.size(), 0);
        checkOutput("idle_oe_n", hub75_oe_n, 1);

        // 4x4 panel, 2 planes: swap requested mid-frame, enable dropped mid-frame
        clear_obs();
        ctrl_en = 1'b1;
        for (int i = 0; i < 300 && fd_cyc < 0; i++) begin
            swap_req = (i == 10);
            if (i == 30) ctrl_en = 1'b0;
            applyStimulus();
        end
        swap_req = 1'b0;
        checkOutput("frame1_seen", fd_cyc >= 0, 1);
        checkOutput("frame1_len", fd_cyc - first_read, 67);
        checkOutput("frame1_sclk", clk_cnt, 16);
`ifndef SCAN_BRIGHTNESS_EN
        checkOutput("frame1_oe_low", oe_low, 24);
`endif
        checkOutput("frame1_ack_cnt", ack_cnt, 1);
        checkOutput("frame1_ack_at_fd", ack_cyc, fd_cyc);
        checkOutput("frame1_rgb_pix3", rgb_t8, 'h2A);
        checkOutput("frame1_clk_low_t8", clk_t8, 0);
        checkOutput("frame1_clk_high_t9", clk_t9, 1);
        checkOutput("frame1_nreads", reads.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < reads.size()) begin
                checkOutput("frame1_read_addr", reads[i], exp_addr[i]);
                checkOutput("frame1_read_bit", read_bits[i], exp_bits[i]);
            end
        end
        repeat (20) applyStimulus();
        checkOutput("after_frame_idle_reads", reads.size(), 16);
        checkOutput("after_frame_buffer", fb_r_buffer, 1);
        checkOutput("after_frame_oe_n", hub75_oe_n, 1);

        // Swap request landing on the frame_done edge, then wrap
        clear_obs();
        ctrl_en = 1'b1;
        for (int i = 0; i < 300 && fd_cyc < 0; i++) begin
            swap_req = (exp_q.size() > 0) && exp_q[0].fd;
            applyStimulus();
        end
        swap_req = 1'b0;
        checkOutput("coinc_seen", fd_cyc >= 0, 1);
        checkOutput("coinc_ack_cnt", ack_cnt, 1);
        checkOutput("coinc_ack_at_fd", ack_cyc, fd_cyc);
        checkOutput("coinc_buffer", fb_r_buffer, 0);
        applyStimulus();
        checkOutput("wrap_read_en", fb_r_en, 1);
        checkOutput("wrap_read_addr", fb_r_addr, 0);

        // Randomized run
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                ctrl_n_rows   = 32'(2 * $urandom_range(1, 4));
                ctrl_n_cols   = 32'($urandom_range(1, 6));
                ctrl_bitdepth = 32'($urandom_range(1, 3));
                case ($urandom_range(0, 11))
                    0: ctrl_n_rows   = 32'($urandom_range(0, 1));
                    1: ctrl_n_cols   = 32'd0;
                    2: ctrl_bitdepth = 32'd0;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 399) == 0) ctrl_en = ($urandom_range(0, 4) != 0);
            swap_req = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 2999) == 0);
            applyStimulus();
        end
        rst = 1'b0;
        swap_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
